// File: rtl/bms_share_controller.sv
// Sequencer for the 4-cell current-sharing datapath: picks SOC / 1/SOC / zero split mode, waits out the datapath latency, captures shares.
// Optional build macro BMS_MODE_HYST_EN adds direction hysteresis on dp_sel.
module bms_share_controller #(
    parameter int W        = 32,
    parameter int DIV_LAT  = 4,
    parameter int HYST_CNT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         cur_gt,
    input  logic         cur_lt,
    input  logic         cur_eq,
    output logic         dp_sel,
    output logic         dp_eqz,
    input  logic [W-1:0] dp_i1,
    input  logic [W-1:0] dp_i2,
    input  logic [W-1:0] dp_i3,
    input  logic [W-1:0] dp_i4,
    output logic [W-1:0] i1,
    output logic [W-1:0] i2,
    output logic [W-1:0] i3,
    output logic [W-1:0] i4,
    output logic         out_valid,
    output logic         busy,
    output logic         flag_err
);

    typedef enum logic [1:0] {IDLE, SETUP, WAIT, CAPTURE} state_t;

    localparam int CW = $clog2(DIV_LAT + 1);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          one_hot;
    logic          dir_req;

`ifdef BMS_MODE_HYST_EN
    localparam int HW = $clog2(HYST_CNT + 1);
    logic [HW-1:0] hyst_cnt;
`endif

    always_comb begin
        one_hot = (({cur_gt, cur_lt, cur_eq} == 3'b100) ||
                   ({cur_gt, cur_lt, cur_eq} == 3'b010) ||
                   ({cur_gt, cur_lt, cur_eq} == 3'b001));
        dir_req = one_hot && !cur_eq;
    end

    assign busy = (state != IDLE);

    // Mode select is decided from the flags sampled with start, so dp_sel/dp_eqz
    // move only on the edge entering SETUP and stay put until the next request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            dp_sel    <= 1'b0;
            dp_eqz    <= 1'b1;
            i1        <= '0;
            i2        <= '0;
            i3        <= '0;
            i4        <= '0;
            out_valid <= 1'b0;
            flag_err  <= 1'b0;
`ifdef BMS_MODE_HYST_EN
            hyst_cnt  <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dp_eqz <= !dir_req;
                        if (!one_hot)
                            flag_err <= 1'b1;
`ifdef BMS_MODE_HYST_EN
                        if (dir_req) begin
                            if (cur_lt != dp_sel) begin
                                if (int'(hyst_cnt) >= HYST_CNT - 1) begin
                                    dp_sel   <= cur_lt;
                                    hyst_cnt <= '0;
                                end else begin
                                    hyst_cnt <= hyst_cnt + 1'b1;
                                end
                            end else begin
                                hyst_cnt <= '0;
                            end
                        end
`else
                        if (dir_req)
                            dp_sel <= cur_lt;
`endif
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    wait_cnt <= CW'(DIV_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0)
                        state <= CAPTURE;
                    else
                        wait_cnt <= wait_cnt - 1'b1;
                end
                CAPTURE: begin
                    i1        <= dp_i1;
                    i2        <= dp_i2;
                    i3        <= dp_i3;
                    i4        <= dp_i4;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bms_share_controller.sv
// Scoreboard bench for bms_share_controller: stimulus pushes expected captures, a monitor checks them on out_valid.
// Build with BMS_MODE_HYST_EN to also exercise the hysteresis sequences.
module tb_bms_share_controller;

    localparam int W       = 32;
    localparam int DIV_LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cur_gt = 1'b0;
    logic         cur_lt = 1'b0;
    logic         cur_eq = 1'b0;
    logic [W-1:0] dp_i1 = '0;
    logic [W-1:0] dp_i2 = '0;
    logic [W-1:0] dp_i3 = '0;
    logic [W-1:0] dp_i4 = '0;
    logic         dp_sel;
    logic         dp_eqz;
    logic [W-1:0] i1;
    logic [W-1:0] i2;
    logic [W-1:0] i3;
    logic [W-1:0] i4;
    logic         out_valid;
    logic         busy;
    logic         flag_err;

    bms_share_controller #(.W(W), .DIV_LAT(DIV_LAT), .HYST_CNT(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cur_gt(cur_gt), .cur_lt(cur_lt), .cur_eq(cur_eq),
        .dp_sel(dp_sel), .dp_eqz(dp_eqz),
        .dp_i1(dp_i1), .dp_i2(dp_i2), .dp_i3(dp_i3), .dp_i4(dp_i4),
        .i1(i1), .i2(i2), .i3(i3), .i4(i4),
        .out_valid(out_valid), .busy(busy), .flag_err(flag_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] v1;
        logic [W-1:0] v2;
        logic [W-1:0] v3;
        logic [W-1:0] v4;
        int           at;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest outstanding expectation, including its edge.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_valid actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check_output("cap_i1", i1, mon_e.v1);
                check_output("cap_i2", i2, mon_e.v2);
                check_output("cap_i3", i3, mon_e.v3);
                check_output("cap_i4", i4, mon_e.v4);
                check_output("cap_cycle", W'(cyc), W'(mon_e.at));
            end
        end
    end

    task automatic set_data(input logic [W-1:0] base);
        dp_i1 = base;
        dp_i2 = base + 32'd1;
        dp_i3 = base + 32'd2;
        dp_i4 = base + 32'd3;
    endtask

    task automatic push_expect(input int start_edge);
        exp_t e;
        e.v1 = dp_i1;
        e.v2 = dp_i2;
        e.v3 = dp_i3;
        e.v4 = dp_i4;
        e.at = start_edge + DIV_LAT + 2;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout actual=busy expected=idle", name);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply_stimulus(input string name, input logic gt, input logic lt, input logic eq,
                                  input logic exp_sel, input logic exp_eqz, input logic exp_err);
        @(negedge clk);
        cur_gt = gt;
        cur_lt = lt;
        cur_eq = eq;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_expect(cyc);
        check_output({name, "_busy"}, W'(busy), W'(1'b1));
        @(posedge clk);
        #1;
        check_output({name, "_sel"}, W'(dp_sel), W'(exp_sel));
        check_output({name, "_eqz"}, W'(dp_eqz), W'(exp_eqz));
        check_output({name, "_err"}, W'(flag_err), W'(exp_err));
        wait_idle(name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        apply_reset();
        #1;
        check_output("rst_sel", W'(dp_sel), W'(1'b0));
        check_output("rst_eqz", W'(dp_eqz), W'(1'b1));
        check_output("rst_i1", i1, '0);
        check_output("rst_i4", i4, '0);
        check_output("rst_busy", W'(busy), W'(1'b0));
        check_output("rst_valid", W'(out_valid), W'(1'b0));
        check_output("rst_err", W'(flag_err), W'(1'b0));

        set_data(32'h3E80_0000);
        apply_stimulus("discharge", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        set_data(32'h3F00_0000);
        apply_stimulus("charge", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        set_data(32'h0000_0000);
        apply_stimulus("zero", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        set_data(32'h4000_0000);
        apply_stimulus("twohot", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        set_data(32'h3DCC_CCCD);
        apply_stimulus("after_err", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Start held high: accepted every DIV_LAT+3 edges, at offsets 0, 7 and 14.
        set_data(32'h3E4C_CCCD);
        @(negedge clk);
        cur_gt = 1'b1;
        cur_lt = 1'b0;
        cur_eq = 1'b0;
        start  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (k % (DIV_LAT + 3) == 0) push_expect(cyc);
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle("held");
        @(negedge clk);
        check_output("held_sb_empty", W'(sb_q.size()), '0);

        // Reset during WAIT: no capture may follow.
        set_data(32'h1234_5678);
        @(negedge clk);
        cur_gt = 1'b0;
        cur_lt = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_output("abort_busy", W'(busy), W'(1'b0));
        check_output("abort_i1", i1, '0);
        check_output("abort_sel", W'(dp_sel), W'(1'b0));
        check_output("abort_eqz", W'(dp_eqz), W'(1'b1));
        check_output("abort_err", W'(flag_err), W'(1'b0));

`ifdef BMS_MODE_HYST_EN
        set_data(32'h3F80_0000);
        apply_stimulus("hyst_lt1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus("hyst_lt2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus("hyst_eq", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        apply_stimulus("hyst_lt3", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_reset();
        apply_stimulus("hyst_b_lt", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus("hyst_b_gt", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus("hyst_b_lt2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check_output("final_sb_empty", W'(sb_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
